// File: rtl/jk_counter_bank.sv
// jk_counter_bank
//   WIDTH-bit bank of JK stages with four modes selected by `mode`:
//     00 JK   : raw per-bit J/K from the j/k ports
//     01 UP   : modulo (MAX_VAL+1) up-count
//     10 DOWN : modulo (MAX_VAL+1) down-count
//     11 LOAD : parallel load of load_val, clipped to MAX_VAL
//   Counting and load modes drive every stage with J=K=toggle terms, so the
//   storage element is always a plain JK stage.
//
//   Optional build macro JKC_SATURATE_EN: UP holds at MAX_VAL and DOWN holds
//   at 0 instead of wrapping. An out-of-range DOWN still lands on MAX_VAL.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high; forces q to 0 over en and mode
//   en       in   state-update enable; 0 holds q in every mode
//   mode     in   [1:0] operating mode (see above)
//   j, k     in   [WIDTH-1:0] per-bit J/K, used in JK mode only
//   load_val in   [WIDTH-1:0] load data, used in LOAD mode only
//   q        out  [WIDTH-1:0] registered state
//   q_       out  [WIDTH-1:0] always ~q
//   tc       out  terminal count (combinational), for cascading

// Single JK storage bit. The enable sits here so that en=0 holds the state
// whatever J/K are doing.
module jk_stage (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= 1'b0;
        else if (en)
            q <= (j & ~q) | (~k & q);
    end

endmodule

module jk_counter_bank #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_,
    output logic             tc
);

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    generate
        if (WIDTH < 1 || WIDTH > 16)
            $error("jk_counter_bank: WIDTH must be 1..16");
        if (MAX_VAL < 1 || MAX_VAL > (2**WIDTH) - 1)
            $error("jk_counter_bank: MAX_VAL must be 1..2**WIDTH-1");
    endgenerate

    mode_e            mode_e_w;
    logic [WIDTH-1:0] up_t;    // bit i toggles on +1 when all lower bits are 1
    logic [WIDTH-1:0] dn_t;    // bit i toggles on -1 when all lower bits are 0
    logic [WIDTH-1:0] tog;     // J=K toggle terms for counting/load modes
    logic [WIDTH-1:0] jv;
    logic [WIDTH-1:0] kv;

    assign mode_e_w = mode_e'(mode);

    // Ripple carry/borrow chains expressed as toggle enables.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chain
            if (gi == 0) begin : g_lsb
                assign up_t[gi] = 1'b1;
                assign dn_t[gi] = 1'b1;
            end else begin : g_upper
                assign up_t[gi] = up_t[gi-1] &  q[gi-1];
                assign dn_t[gi] = dn_t[gi-1] & ~q[gi-1];
            end
        end
    endgenerate

    // Jumps to an arbitrary value (wrap, clip, load) reuse the toggle path:
    // toggling exactly the bits in q ^ target lands on target in one edge.
    always_comb begin
        tog = '0;
        unique case (mode_e_w)
            MODE_JK: tog = '0;
            MODE_UP: begin
                if (q >= MAX_Q)
`ifdef JKC_SATURATE_EN
                    tog = q ^ MAX_Q;
`else
                    tog = q;                 // q ^ 0
`endif
                else
                    tog = up_t;
            end
            MODE_DOWN: begin
                if (q > MAX_Q)
                    tog = q ^ MAX_Q;
                else if (q == '0)
`ifdef JKC_SATURATE_EN
                    tog = '0;
`else
                    tog = MAX_Q;             // 0 ^ MAX_Q
`endif
                else
                    tog = dn_t;
            end
            MODE_LOAD: begin
                if (load_val > MAX_Q)
                    tog = q ^ MAX_Q;
                else
                    tog = q ^ load_val;
            end
            default: tog = '0;
        endcase
    end

    assign jv = (mode_e_w == MODE_JK) ? j : tog;
    assign kv = (mode_e_w == MODE_JK) ? k : tog;

    jk_stage u_stage [WIDTH-1:0] (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .j     (jv),
        .k     (kv),
        .q     (q)
    );

    assign q_ = ~q;

    assign tc = en & (((mode_e_w == MODE_UP)   && (q == MAX_Q)) ||
                      ((mode_e_w == MODE_DOWN) && (q == '0)));

endmodule

// File: tb/tb_jk_counter_bank.sv
module tb_jk_counter_bank;

    localparam int W   = 4;
    localparam int MAX = 9;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] j, k, load_val;
    logic [W-1:0] q, q_;
    logic         tc;

    int checks = 0;
    int errors = 0;

    int   mq;          // reference count value
    logic tc_seen;     // tc observed just before the edge
    logic tc_exp;      // tc predicted for the same inputs

    jk_counter_bank #(.WIDTH(W), .MAX_VAL(MAX)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .j        (j),
        .k        (k),
        .load_val (load_val),
        .q        (q),
        .q_       (q_),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    // Reference model: arithmetic rules of each mode.
    function automatic int model_next(input int cur, input logic r, input logic e,
                                      input logic [1:0] m, input logic [W-1:0] jj,
                                      input logic [W-1:0] kk, input logic [W-1:0] lv);
        logic [W-1:0] c;
        c = cur[W-1:0];
        if (r) return 0;
        if (!e) return cur;
        case (m)
            2'd0: return int'((jj & ~c) | (~kk & c));
`ifdef JKC_SATURATE_EN
            2'd1: return (cur >= MAX) ? MAX : cur + 1;
            2'd2: return (cur > MAX) ? MAX : (cur == 0) ? 0 : cur - 1;
`else
            2'd1: return (cur >= MAX) ? 0 : cur + 1;
            2'd2: return (cur > MAX || cur == 0) ? MAX : cur - 1;
`endif
            default: return (int'(lv) > MAX) ? MAX : int'(lv);
        endcase
    endfunction

    function automatic logic model_tc(input int cur, input logic e, input logic [1:0] m);
        return e && ((m == 2'd1 && cur == MAX) || (m == 2'd2 && cur == 0));
    endfunction

    // Drive one cycle of inputs, sample tc before the edge, advance the model.
    task automatic tick(input logic r, input logic e, input logic [1:0] m,
                        input logic [W-1:0] jj, input logic [W-1:0] kk,
                        input logic [W-1:0] lv);
        reset = r; en = e; mode = m; j = jj; k = kk; load_val = lv;
        #1;
        tc_seen = tc;
        tc_exp  = model_tc(mq, e, m);
        @(posedge clk);
        #1;
        mq = model_next(mq, r, e, m, jj, kk, lv);
    endtask

    task automatic test_reset;
        tick(1'b1, 1'b0, 2'd0, '0, '0, '0);
        tick(1'b1, 1'b0, 2'd0, '0, '0, '0);
        checks++;
        if (q !== 4'h0 || q_ !== 4'hF) begin
            errors++;
            $display("FAIL reset_state q=%h q_=%h want q=0 q_=F", q, q_);
        end
        // count to 5, then reset for 2 edges while still in UP
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 2'd1, '0, '0, '0);
        checks++;
        if (q !== 4'd5) begin
            errors++;
            $display("FAIL reset_precount q=%0d want 5", q);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1, 2'd1, '0, '0, '0);
            checks++;
            if (q !== 4'h0 || q_ !== 4'hF) begin
                errors++;
                $display("FAIL reset_midcount edge%0d q=%h q_=%h want 0/F", i, q, q_);
            end
        end
        #1;
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL reset_tc tc=%b want 0", tc);
        end
        tick(1'b0, 1'b1, 2'd1, '0, '0, '0);
        checks++;
        if (q !== 4'd1) begin
            errors++;
            $display("FAIL reset_release q=%0d want 1", q);
        end
    endtask

    task automatic test_jk;
        tick(1'b0, 1'b1, 2'd3, '0, '0, 4'b0110);
        tick(1'b0, 1'b1, 2'd0, 4'b1010, 4'b0110, '0);
        checks++;
        if (q !== 4'b1000 || q_ !== 4'b0111 || tc_seen !== 1'b0) begin
            errors++;
            $display("FAIL jk_truth q=%b q_=%b tc=%b want 1000/0111/0", q, q_, tc_seen);
        end
    endtask

    task automatic test_up_wrap;
        int exp_q [12];
`ifdef JKC_SATURATE_EN
        exp_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
`else
        exp_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
`endif
        tick(1'b1, 1'b0, 2'd0, '0, '0, '0);
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b1, 2'd1, '0, '0, '0);
            checks++;
            if (int'(q) !== exp_q[i] || tc_seen !== tc_exp ||
                tc_exp !== ((i > 0 && exp_q[i-1] == 9) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL up_wrap step%0d q=%0d want %0d tc=%b want %b",
                         i, q, exp_q[i], tc_seen, tc_exp);
            end
        end
    endtask

    task automatic test_down_wrap;
        int exp_q [4];
`ifdef JKC_SATURATE_EN
        exp_q = '{1, 0, 0, 0};
`else
        exp_q = '{1, 0, 9, 8};
`endif
        tick(1'b0, 1'b1, 2'd3, '0, '0, 4'd2);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, 2'd2, '0, '0, '0);
            checks++;
            if (int'(q) !== exp_q[i] || tc_seen !== tc_exp ||
                tc_exp !== ((i > 0 && exp_q[i-1] == 0) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL down_wrap step%0d q=%0d want %0d tc=%b want %b",
                         i, q, exp_q[i], tc_seen, tc_exp);
            end
        end
    endtask

    task automatic test_hold_clip;
        tick(1'b0, 1'b1, 2'd3, '0, '0, 4'd7);
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 3; i++) begin
                tick(1'b0, 1'b0, 2'(m), 4'hF, 4'h5, 4'h3);
                checks++;
                if (q !== 4'd7 || tc_seen !== 1'b0) begin
                    errors++;
                    $display("FAIL hold mode%0d q=%0d want 7 tc=%b want 0", m, q, tc_seen);
                end
            end
        end
        tick(1'b0, 1'b1, 2'd3, '0, '0, 4'hC);
        checks++;
        if (q !== 4'd9) begin
            errors++;
            $display("FAIL load_clip q=%0d want 9", q);
        end
    endtask

    task automatic test_out_of_range;
        tick(1'b0, 1'b1, 2'd0, 4'b1100, 4'b0011, '0);
        checks++;
        if (q !== 4'hC) begin
            errors++;
            $display("FAIL oor_set q=%h want C", q);
        end
        tick(1'b0, 1'b1, 2'd1, '0, '0, '0);
        checks++;
`ifdef JKC_SATURATE_EN
        if (q !== 4'd9) begin
            errors++;
            $display("FAIL oor_up q=%0d want 9", q);
        end
`else
        if (q !== 4'd0) begin
            errors++;
            $display("FAIL oor_up q=%0d want 0", q);
        end
`endif
        tick(1'b0, 1'b1, 2'd0, 4'b1100, 4'b0011, '0);
        tick(1'b0, 1'b1, 2'd2, '0, '0, '0);
        checks++;
        if (q !== 4'd9) begin
            errors++;
            $display("FAIL oor_down q=%0d want 9", q);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 29) == 0), ($urandom_range(0, 4) != 0),
                 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom));
            checks++;
            if (int'(q) !== mq || q_ !== ~q || tc_seen !== tc_exp) begin
                errors++;
                $display("FAIL random cyc%0d q=%0d q_=%h tc=%b want q=%0d tc=%b",
                         i, q, q_, tc_seen, mq, tc_exp);
            end
        end
    endtask

    initial begin
        mq = 0;
        reset = 1'b1; en = 1'b0; mode = 2'd0; j = '0; k = '0; load_val = '0;
        test_reset();
        test_jk();
        test_up_wrap();
        test_down_wrap();
        test_hold_clip();
        test_out_of_range();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
